// File: rtl/fc_pkg.sv
// Shared definitions for the FC-layer output stage.
// Holds the argmax FSM state encoding and the default score width / class count
// used by the FC accumulator path.
package fc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } fc_state_t;

    localparam int FC_DATA_W      = 16;
    localparam int FC_NUM_CLASSES = 10;

endpackage

// File: rtl/argmax_cmp.sv
// Strict greater-than comparator (gt = a > b), signed or unsigned by parameter.
// Latency: purely combinational. Backpressure: none, no handshake.
// Ports: a, b - DATA_W operands; gt - 1 when a is strictly greater than b.
module argmax_cmp #(
    parameter int DATA_W = 16,
    parameter int SIGNED = 1
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              gt
);

    generate
        if (SIGNED != 0) begin : g_signed
            assign gt = $signed(a) > $signed(b);
        end else begin : g_unsigned
            assign gt = a > b;
        end
    endgenerate

endmodule

// File: rtl/argmax_stream.sv
// Streaming argmax: scans NUM_CLASSES scores, reports max/index, runner-up index and margin.
// Latency: done pulses the cycle after the last score is accepted; results are valid during it.
// Backpressure: in_ready is high only while scanning; in_valid low stalls without state change.
// Ports: clk/reset (async, active-high); enable starts a frame from IDLE;
//        in_valid/in_data/in_ready score stream; busy, done status;
//        result/max_value (argmax), result2 (runner-up index), margin (max - runner-up).
module argmax_stream
    import fc_pkg::*;
#(
    parameter int DATA_W      = FC_DATA_W,
    parameter int NUM_CLASSES = FC_NUM_CLASSES,
    parameter int IDX_W       = $clog2(NUM_CLASSES),
    parameter int SIGNED      = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  result,
    output logic [DATA_W-1:0] max_value,
    output logic [IDX_W-1:0]  result2,
    output logic [DATA_W-1:0] margin
);

    fc_state_t state, state_nxt;

    logic [IDX_W-1:0]  cnt;
    logic [DATA_W-1:0] max_r, run_r;
    logic [IDX_W-1:0]  imax_r, irun_r;

    logic [DATA_W-1:0] max_nxt, run_nxt;
    logic [IDX_W-1:0]  imax_nxt, irun_nxt;
    logic [DATA_W:0]   diff_nxt;

    logic accept, last, gt_max, gt_run;

    assign accept   = (state == SCAN) && in_valid;
    assign last     = (cnt == IDX_W'(NUM_CLASSES - 1));
    // One extra bit so the difference is exact before truncation; max >= runner-up keeps it in range.
    assign diff_nxt = {1'b0, max_nxt} - {1'b0, run_nxt};

    argmax_cmp #(.DATA_W(DATA_W), .SIGNED(SIGNED)) u_cmp_max (
        .a  (in_data),
        .b  (max_r),
        .gt (gt_max)
    );

    argmax_cmp #(.DATA_W(DATA_W), .SIGNED(SIGNED)) u_cmp_run (
        .a  (in_data),
        .b  (run_r),
        .gt (gt_run)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = SCAN;
            SCAN:    if (accept && last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            SCAN:    begin in_ready = 1'b1; busy = 1'b1; end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Tracking update for the element being accepted. Strict compares keep the
    // lowest index on ties. At index 1 the runner-up register still holds stale
    // data, so the element becomes runner-up without comparing against it.
    always_comb begin
        max_nxt  = max_r;
        imax_nxt = imax_r;
        run_nxt  = run_r;
        irun_nxt = irun_r;
        if (cnt == '0) begin
            max_nxt  = in_data;
            imax_nxt = '0;
        end else if (gt_max) begin
            run_nxt  = max_r;
            irun_nxt = imax_r;
            max_nxt  = in_data;
            imax_nxt = cnt;
        end else if ((cnt == IDX_W'(1)) || gt_run) begin
            run_nxt  = in_data;
            irun_nxt = cnt;
        end
    end

    // Datapath. Result registers load on the edge that enters DONE, so they
    // already show the new frame while done is high, and hold afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            max_r     <= '0;
            imax_r    <= '0;
            run_r     <= '0;
            irun_r    <= '0;
            result    <= '0;
            max_value <= '0;
            result2   <= '0;
            margin    <= '0;
        end else begin
            if (state == IDLE && enable) begin
                cnt <= '0;
            end else if (accept && !last) begin
                cnt <= cnt + 1'b1;
            end
            if (accept) begin
                max_r  <= max_nxt;
                imax_r <= imax_nxt;
                run_r  <= run_nxt;
                irun_r <= irun_nxt;
                if (last) begin
                    result    <= imax_nxt;
                    max_value <= max_nxt;
                    result2   <= irun_nxt;
                    margin    <= diff_nxt[DATA_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_argmax_stream.sv
module tb_argmax_stream;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        in_valid;
    logic [15:0] in_data;

    logic        rdy_s, busy_s, done_s, rdy_u, busy_u, done_u;
    logic [3:0]  res_s, res2_s, res_u, res2_u;
    logic [15:0] max_s, mg_s, max_u, mg_u;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    logic [15:0] frame [10];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    argmax_stream #(.DATA_W(16), .NUM_CLASSES(10), .IDX_W(4), .SIGNED(1)) dut_s (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_s), .busy(busy_s), .done(done_s), .result(res_s),
        .max_value(max_s), .result2(res2_s), .margin(mg_s)
    );

    argmax_stream #(.DATA_W(16), .NUM_CLASSES(10), .IDX_W(4), .SIGNED(0)) dut_u (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_u), .busy(busy_u), .done(done_u), .result(res_u),
        .max_value(max_u), .result2(res2_u), .margin(mg_u)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        enable = 1'b1;
        step();
        enable = 1'b0;
    endtask

    // Present element k after 'gap' idle cycles; returns after its acceptance edge.
    task automatic feed(input int k, input int gap);
        in_valid = 1'b0;
        repeat (gap) step();
        in_valid = 1'b1;
        in_data  = frame[k];
        step();
        in_valid = 1'b0;
    endtask

    // Full frame; checks done timing and that nothing finished early.
    task automatic run_frame(input string tag, input int gap);
        int  first;
        bit  early;
        early = 1'b0;
        first = 0;
        start_frame();
        check({tag, "_busy_scan"}, {busy_s, rdy_s}, 2'b11);
        for (int k = 0; k < 10; k++) begin
            feed(k, gap);
            if (k == 0) first = cyc;
            if (k < 9) early |= done_s | done_u;
        end
        check({tag, "_no_early_done"}, early, 0);
        check({tag, "_done_pulse"}, {done_s, busy_s, rdy_s}, 3'b100);
        check({tag, "_edges_first_to_done"}, cyc - first, 9 * (gap + 1));
    endtask

    task automatic check_s(input string tag, input int r, input int m, input int r2, input int mg);
        check({tag, "_result"}, res_s, r);
        check({tag, "_max_value"}, max_s, m);
        check({tag, "_result2"}, res2_s, r2);
        check({tag, "_margin"}, mg_s, mg);
    endtask

    task automatic check_u(input string tag, input int r, input int r2);
        check({tag, "_u_result"}, res_u, r);
        check({tag, "_u_result2"}, res2_u, r2);
    endtask

    task automatic load(input logic [15:0] v0, v1, v2, v3, v4, v5, v6, v7, v8, v9);
        frame[0] = v0; frame[1] = v1; frame[2] = v2; frame[3] = v3; frame[4] = v4;
        frame[5] = v5; frame[6] = v6; frame[7] = v7; frame[8] = v8; frame[9] = v9;
    endtask

    initial begin
        bit ghost;
        reset    = 1'b1;
        enable   = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        step();
        step();
        check("reset_ctrl", {rdy_s, busy_s, done_s}, 0);
        check("reset_data", {res_s, max_s, res2_s, mg_s}, 0);
        reset = 1'b0;
        step();

        // Data offered in IDLE must be dropped.
        in_valid = 1'b1;
        in_data  = 16'h7FFF;
        step();
        check("idle_not_ready", {rdy_s, rdy_u}, 0);

        // Baseline: edge of first acceptance to done edge is 9 edges, i.e. done
        // in cycle 11 counting the first acceptance cycle as cycle 1.
        load(16'h0800, 16'h0000, 16'h0001, 16'h0002, 16'h0004,
             16'h0008, 16'h0010, 16'h0020, 16'h0040, 16'h0080);
        run_frame("base", 0);
        check_s("base", 0, 16'h0800, 9, 16'h0780);
        check_u("base", 0, 9);
        step();
        check("base_done_one_cycle", {done_s, busy_s}, 0);
        check("base_hold", {res_s, max_s, res2_s, mg_s}, {4'd0, 16'h0800, 4'd9, 16'h0780});

        // Negative scores: signed and unsigned both give argmax 2, runner-up 0.
        load(16'hFFF0, 16'h8000, 16'hFFFF, 16'h8000, 16'h8000,
             16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
        run_frame("neg", 0);
        check_s("neg", 2, 16'hFFFF, 0, 16'h000F);
        check_u("neg", 2, 0);
        check("neg_u_margin", mg_u, 16'h000F);
        step();

        // All equal: lowest indices win.
        load(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100,
             16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
        run_frame("tie", 0);
        check_s("tie", 0, 16'h0100, 1, 0);
        step();

        // Tie at the top between indices 3 and 7.
        load(0, 0, 0, 16'h0005, 0, 0, 0, 16'h0005, 0, 0);
        run_frame("toptie", 0);
        check_s("toptie", 3, 16'h0005, 7, 0);
        check_u("toptie", 3, 7);
        step();

        // Baseline with 3 idle cycles before every element.
        load(16'h0800, 16'h0000, 16'h0001, 16'h0002, 16'h0004,
             16'h0008, 16'h0010, 16'h0020, 16'h0040, 16'h0080);
        run_frame("gap", 3);
        check_s("gap", 0, 16'h0800, 9, 16'h0780);
        step();

        // Abort a frame after element 5 with an asynchronous reset.
        load(16'h7000, 16'h7001, 16'h7002, 16'h7003, 16'h7004,
             16'h7005, 16'h7006, 16'h7007, 16'h7008, 16'h7009);
        start_frame();
        for (int k = 0; k < 6; k++) feed(k, 0);
        in_valid = 1'b1;
        in_data  = 16'h7FFF;
        #2;
        reset = 1'b1;
        #1;
        check("abort_async_outputs", {res_s, max_s, res2_s, mg_s}, 0);
        check("abort_async_ctrl", {rdy_s, busy_s, done_s}, 0);
        step();
        reset = 1'b0;
        ghost = 1'b0;
        repeat (12) begin
            step();
            ghost |= done_s | done_u;
        end
        check("abort_no_done", ghost, 0);
        in_valid = 1'b0;

        // Clean frame with max at index 9.
        load(1, 2, 3, 4, 5, 6, 7, 8, 9, 10);
        run_frame("post", 0);
        check_s("post", 9, 10, 8, 1);
        check_u("post", 9, 8);
        step();

        // Enable pulsed mid-scan must not restart the count.
        load(3, 1, 4, 1, 5, 9, 2, 6, 5, 3);
        start_frame();
        ghost = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k == 4) enable = 1'b1;
            feed(k, 0);
            enable = 1'b0;
            if (k < 9) ghost |= done_s;
        end
        check("en_scan_no_early", ghost, 0);
        check("en_scan_done", done_s, 1);
        check_s("en_scan", 5, 9, 7, 3);

        // Enable held through DONE: ignored there, then starts a frame from IDLE.
        enable = 1'b1;
        step();
        check("en_hold_idle", {busy_s, rdy_s, done_s}, 0);
        step();
        check("en_hold_restart", {busy_s, rdy_s}, 2'b11);
        enable = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/argmax_stream.md
Name: argmax_stream

Overview:
- Parametrised successor to the FC-layer output comparator.
- Scans NUM_CLASSES scores streamed one per cycle from the FC accumulator and reports:
  - the index of the maximum (the predicted class);
  - the maximum value;
  - the runner-up index;
  - the confidence margin (max minus runner-up).
- Adds a valid/ready input stream, signed or unsigned comparison, and a defined tie-break.
- Sits between the FC output buffer and the result register and host interface.

Parameters:
- DATA_W, 16: score width in bits.
- NUM_CLASSES, 10: scores per frame. Must be 2 or more.
- IDX_W, $clog2(NUM_CLASSES): index width.
- SIGNED, 1: 1 selects two's-complement (fixed-point) comparison; 0 selects unsigned.

Ports:
- clk, in, 1: clock, rising edge.
- reset, in, 1: asynchronous, active-high reset.
- enable, in, 1: start of a frame. Sampled only in IDLE.
- in_valid, in, 1: in_data is valid.
- in_data, in, DATA_W: current score. Scores arrive in index order 0..NUM_CLASSES-1.
- in_ready, out, 1: block accepts in_data this cycle.
- busy, out, 1: a frame is in progress.
- done, out, 1: one-cycle pulse when the results are valid.
- result, out, IDX_W: argmax index.
- max_value, out, DATA_W: the maximum score.
- result2, out, IDX_W: runner-up index.
- margin, out, DATA_W: max_value minus the runner-up score, unsigned.

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE.
  - in_ready, busy, done, result, max_value, result2 and margin all go to 0.
  - The element counter clears.
- FSM states: IDLE, SCAN, DONE.
  - IDLE to SCAN on enable=1. busy and in_ready go to 1 on the next cycle. The counter clears.
  - SCAN: in_ready=1. One score is accepted on each cycle with in_valid and in_ready both high. in_valid=0 cycles stall without state change.
  - SCAN to DONE on acceptance of element NUM_CLASSES-1.
  - DONE: lasts one cycle. done=1, busy=0, in_ready=0. Outputs update this cycle. Next state is IDLE.
  - Latency: done is asserted exactly 1 cycle after the last element is accepted.
- Tracking rules, for accepted element x at index k:
  - k=0: max gets x, imax gets 0.
  - k=1: if x > max, the runner-up gets the old max and index 0, and max/imax get x/1. Otherwise the runner-up gets x and index 1 unconditionally.
  - k≥2:
    - If x > max: the runner-up gets the old max and imax; max and imax get x and k.
    - Else if x > runner-up: the runner-up gets x and k.
    - Else: no change.
- Comparisons are strict (>), so on a tie the lowest index wins for both max and runner-up.
- Comparison is signed when SIGNED=1 and unsigned when SIGNED=0.
- Margin:
  - margin = max minus runner-up, computed DATA_W+1 wide and truncated to DATA_W.
  - It always fits, because max is greater than or equal to the runner-up. Range is 0 to 2^DATA_W-1.
- Output registers:
  - result, max_value, result2 and margin are loaded only in DONE.
  - They hold until the next DONE or reset.
- Boundary conditions:
  - enable during SCAN or DONE is ignored.
  - enable held high continuously starts a new frame on each IDLE cycle.
  - in_valid in IDLE or DONE is not accepted (in_ready=0) and data is dropped.
  - Reset mid-SCAN aborts the frame: outputs go to 0 and no done pulse is produced.
  - The counter never exceeds NUM_CLASSES-1.

Decomposition:
- Shared package fc_pkg holds:
  - the FSM state enum (IDLE/SCAN/DONE);
  - the default DATA_W and NUM_CLASSES constants used by the FC layer.
- One natural sub-module: argmax_cmp, a combinational greater-than with a SIGNED parameter. It is instantiated twice (against max and against runner-up).
- All state stays in the top module.

Test Plan:
- Baseline frame:
  - Stimulus: scores 0x0800, 0, 1, 2, 4, 8, 0x10, 0x20, 0x40, 0x80, in_valid held high.
  - Response: done 11 cycles after the first acceptance; result=0, max_value=0x0800, result2=9, margin=0x0780.
- Signed negatives (SIGNED=1):
  - Stimulus: scores 0xFFF0, 0x8000, 0xFFFF, then 0x8000 ×7.
  - Response: result=2, max_value=0xFFFF, result2=0, margin=0x000F.
  - Repeat with SIGNED=0: result=2 and result2=0 (0xFFFF is largest, 0xFFF0 next).
- Ties:
  - Stimulus: all ten scores equal to 0x0100.
  - Response: result=0, result2=1, margin=0.
- Ties at the top:
  - Stimulus: scores 0x0005 at indices 3 and 7, all others 0.
  - Response: result=3, result2=7.
- Backpressure gaps:
  - Stimulus: the baseline frame with in_valid deasserted for 3 cycles between every element.
  - Response: identical results. done comes 1 cycle after the 10th acceptance. No acceptance occurs during gaps.
- Reset mid-frame and enable while busy:
  - Stimulus: reset after element 5, then a clean frame whose max is at index 9.
  - Response: no done pulse for the aborted frame. Outputs read 0 after reset. The second frame gives result=9.
  - Stimulus: enable pulsed during SCAN.
  - Response: no restart; the count continues.
